// File: rtl/transpose_pkg.sv
// Shared constants for the matrix-transpose datapath, plus the per-stage
// rotate amount used by the log-stage rotator.
package transpose_pkg;

   localparam int unsigned DATA_WIDTH  = 3;
   localparam int unsigned NUM_PE      = 8;
   localparam int unsigned TOTAL_WIDTH = DATA_WIDTH * NUM_PE;

   // Stage i rotates by 2^i, reduced modulo the row width.
   function automatic int unsigned stage_rot(input int unsigned stage,
                                             input int unsigned width);
      return (32'd1 << stage) % width;
   endfunction

endpackage

// File: rtl/circular_shifter_rotate_stage.sv
// One log stage of the rotator: rotates by a constant when the selected amount
// bit is set. Data, valid and amount are either registered or passed through.
module rotate_stage #(
   parameter int unsigned WIDTH      = 24,
   parameter int unsigned AMT_BITS   = 5,
   parameter int unsigned SEL_BIT    = 0,
   parameter int unsigned ROT        = 1,
   parameter bit          ROT_LEFT   = 1'b1,
   parameter bit          REGISTERED = 1'b0
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                valid_i,
   input  logic [WIDTH-1:0]    data_i,
   input  logic [AMT_BITS-1:0] amt_i,
   output logic                valid_o,
   output logic [WIDTH-1:0]    data_o,
   output logic [AMT_BITS-1:0] amt_o
);

   logic [WIDTH-1:0] rot_data;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      if (ROT_LEFT) begin
         rot_data = (data_i << ROT) | (data_i >> (WIDTH - ROT));
      end else begin
         rot_data = (data_i >> ROT) | (data_i << (WIDTH - ROT));
      end
      data_d = amt_i[SEL_BIT] ? rot_data : data_i;
   end

   if (REGISTERED) begin : g_reg
      logic                valid_q;
      logic [WIDTH-1:0]    data_q;
      logic [AMT_BITS-1:0] amt_q;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
         end else begin
            valid_q <= valid_i;
            data_q  <= data_d;
            amt_q   <= amt_i;
         end
      end

      assign valid_o = valid_q;
      assign data_o  = data_q;
      assign amt_o   = amt_q;
   end else begin : g_comb
      assign valid_o = valid_i;
      assign data_o  = data_d;
      assign amt_o   = amt_i;
   end

endmodule

// File: rtl/circular_shifter.sv
// Registered barrel rotator for a packed row; direction fixed at elaboration,
// amount taken at run time and applied as a chain of log stages.
module circular_shifter #(
   parameter int unsigned TOTAL_WIDTH    = transpose_pkg::TOTAL_WIDTH,
   parameter int unsigned SHIFT_DIR      = 1,
   parameter int unsigned PIPELINE       = 0,
   parameter int unsigned SHIFT_AMT_BITS = $clog2(TOTAL_WIDTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [TOTAL_WIDTH-1:0]    input_bits,
   input  logic [SHIFT_AMT_BITS-1:0] shift_amt,
   output logic                      out_valid,
   output logic [TOTAL_WIDTH-1:0]    output_bits
);

   import transpose_pkg::*;

   logic [TOTAL_WIDTH-1:0]    data_s [SHIFT_AMT_BITS+1];
   logic [SHIFT_AMT_BITS-1:0] amt_s  [SHIFT_AMT_BITS+1];
   logic [SHIFT_AMT_BITS:0]   valid_s;

   assign data_s[0]  = input_bits;
   assign amt_s[0]   = shift_amt;
   assign valid_s[0] = in_valid;

   // Without pipelining only the last stage registers, so the whole chain
   // collapses into one combinational rotate ahead of a single output register.
   for (genvar i = 0; i < SHIFT_AMT_BITS; i++) begin : g_stage
      rotate_stage #(
         .WIDTH      (TOTAL_WIDTH),
         .AMT_BITS   (SHIFT_AMT_BITS),
         .SEL_BIT    (i),
         .ROT        (stage_rot(i, TOTAL_WIDTH)),
         .ROT_LEFT   (SHIFT_DIR != 0),
         .REGISTERED ((PIPELINE != 0) || (i == SHIFT_AMT_BITS - 1))
      ) u_stage (
         .clk_i   (clk),
         .reset_i (reset),
         .valid_i (valid_s[i]),
         .data_i  (data_s[i]),
         .amt_i   (amt_s[i]),
         .valid_o (valid_s[i+1]),
         .data_o  (data_s[i+1]),
         .amt_o   (amt_s[i+1])
      );
   end

   assign out_valid   = valid_s[SHIFT_AMT_BITS];
   assign output_bits = data_s[SHIFT_AMT_BITS];

endmodule

// File: tb/tb_circular_shifter.sv
// Scoreboard bench: left/unpipelined, right/unpipelined and left/pipelined
// rotators share one stimulus stream; a monitor checks data and arrival cycle.
module tb_circular_shifter;

   localparam int unsigned W   = 24;
   localparam int unsigned AB  = 5;
   localparam int unsigned NV  = 10;
   localparam int unsigned LAT_P0 = 1;
   localparam int unsigned LAT_P1 = 5;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  due;
   } exp_t;

   logic          clk        = 1'b0;
   logic          reset      = 1'b1;
   logic          in_valid   = 1'b0;
   logic [W-1:0]  input_bits = '0;
   logic [AB-1:0] shift_amt  = '0;
   logic [2:0]    ov;
   logic [W-1:0]  ob [3];

   exp_t        q [3][$];
   exp_t        mon_e;
   int unsigned cyc   = 0;
   int          total = 0;
   int          bad   = 0;

   // Hand-computed vectors: input row, amount, left result, right result.
   logic [W-1:0]  v_din [NV] = '{24'hFAC688, 24'hFAC688, 24'hFAC688, 24'hFAC688, 24'hFAC688,
                                 24'hFAC688, 24'hFAC688, 24'h800001, 24'hFFFFFF, 24'h000000};
   logic [AB-1:0] v_amt [NV] = '{5'd0, 5'd15, 5'd21, 5'd25, 5'd3,
                                 5'd24, 5'd31, 5'd1, 5'd13, 5'd7};
   logic [W-1:0]  v_l   [NV] = '{24'hFAC688, 24'h447D63, 24'h1F58D1, 24'hF58D11, 24'hD63447,
                                 24'hFAC688, 24'h63447D, 24'h000003, 24'hFFFFFF, 24'h000000};
   logic [W-1:0]  v_r   [NV] = '{24'hFAC688, 24'h8D11F5, 24'hD63447, 24'h7D6344, 24'h1F58D1,
                                 24'hFAC688, 24'h11F58D, 24'hC00000, 24'hFFFFFF, 24'h000000};

   circular_shifter #(.TOTAL_WIDTH(W), .SHIFT_DIR(1), .PIPELINE(0)) u_l0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .input_bits(input_bits),
      .shift_amt(shift_amt), .out_valid(ov[0]), .output_bits(ob[0]));

   circular_shifter #(.TOTAL_WIDTH(W), .SHIFT_DIR(0), .PIPELINE(0)) u_r0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .input_bits(input_bits),
      .shift_amt(shift_amt), .out_valid(ov[1]), .output_bits(ob[1]));

   circular_shifter #(.TOTAL_WIDTH(W), .SHIFT_DIR(1), .PIPELINE(1)) u_l1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .input_bits(input_bits),
      .shift_amt(shift_amt), .out_valid(ov[2]), .output_bits(ob[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int d,
                        input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d got=%h want=%h", name, d, act, exp);
      end
   endtask

   // Monitor: every valid output must match the oldest expectation, on time.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ov[d] === 1'b1) begin
            if (q[d].size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_valid dut%0d got=%h want=no_output", d, ob[d]);
            end else begin
               mon_e = q[d].pop_front();
               check("data", d, ob[d], mon_e.data);
               total++;
               if (cyc != mon_e.due) begin
                  bad++;
                  $display("FAIL latency dut%0d got_cycle=%0d want_cycle=%0d", d, cyc, mon_e.due);
               end
            end
         end else if (q[d].size() != 0 && q[d][0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_output dut%0d got=none want=%h", d, q[d][0].data);
            void'(q[d].pop_front());
         end
      end
   end

   task automatic issue(input int unsigned i);
      in_valid   = 1'b1;
      input_bits = v_din[i];
      shift_amt  = v_amt[i];
      q[0].push_back('{data: v_l[i], due: cyc + LAT_P0});
      q[1].push_back('{data: v_r[i], due: cyc + LAT_P0});
      q[2].push_back('{data: v_l[i], due: cyc + LAT_P1});
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         in_valid   = 1'b0;
         input_bits = W'($urandom);
         shift_amt  = AB'($urandom);
         @(negedge clk);
      end
   endtask

   // Drop expectations that a reset now in progress will never let out.
   task automatic prune();
      for (int d = 0; d < 3; d++) begin
         exp_t keep [$];
         foreach (q[d][k]) begin
            if (q[d][k].due <= cyc) keep.push_back(q[d][k]);
         end
         q[d] = keep;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_valid", d, W'(ov[d]), '0);
         check("reset_data", d, ob[d], '0);
      end
      reset = 1'b0;

      for (int unsigned i = 0; i < NV; i++) issue(i);
      idle(1);
      for (int unsigned i = 0; i < NV; i++) begin
         issue(i);
         idle(1 + (i % 2));
      end
      idle(8);

      issue(1);
      issue(2);
      issue(3);
      reset      = 1'b1;
      in_valid   = 1'b1;
      input_bits = v_din[1];
      shift_amt  = v_amt[1];
      prune();
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("flush_valid", d, W'(ov[d]), '0);
         check("flush_data", d, ob[d], '0);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      idle(12);

      issue(6);
      issue(0);
      idle(8);

      for (int d = 0; d < 3; d++) begin
         total++;
         if (q[d].size() != 0) begin
            bad++;
            $display("FAIL drained dut%0d got_pending=%0d want_pending=0", d, q[d].size());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
